uart_word_framer: RTL and testbench

//   Parametrised word<->byte framer between the debug unit and the byte-level UART core.
//   TX: splits an NB_DATA word into 1..N_BYTES bytes and sends them one at a time over the byte core's start/done handshake.
//   RX: assembles received bytes into NB_DATA words and discards stale partial words on inactivity timeout.

---
 rtl/uart_word_framer.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_word_framer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_framer.sv
// uart_word_framer: word <-> byte framer between the debug unit and a byte-level UART core.
//   TX side splits an NB_DATA word into 1..N_BYTES bytes and sends them over the
//   byte core's start/done handshake; RX side assembles bytes into words and
//   drops a stale partial word after TIMEOUT_CYCLES idle cycles (0 = never).
// Ports:
//   i_clock, i_reset            clock, asynchronous active-high reset
//   i_tx_data, i_tx_n_bytes     word to send and byte count (0 or >N_BYTES = all)
//   i_tx_start                  send request, accepted only while o_tx_busy=0
//   o_tx_busy, o_tx_done_pulse  transfer in progress / finished
//   o_byte_tx_data/_start       byte and 1-cycle start pulse to the UART TX core
//   i_byte_tx_done              1-cycle pulse from the UART TX core
//   i_byte_rx_data/_done        byte and valid pulse from the UART RX core
//   o_rx_word, o_rx_word_valid  last complete word and its update pulse
//   o_rx_timeout_pulse          a partial word was discarded
module uart_word_framer #(
    parameter int NB_DATA        = 32,
    parameter int NB_BYTE        = 8,
    parameter bit LSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int N_BYTES       = NB_DATA / NB_BYTE,
    localparam int NB_CNT        = $clog2(N_BYTES + 1)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_tx_data,
    input  logic [NB_CNT-1:0]  i_tx_n_bytes,
    input  logic               i_tx_start,
    output logic               o_tx_busy,
    output logic               o_tx_done_pulse,
    output logic [NB_BYTE-1:0] o_byte_tx_data,
    output logic               o_byte_tx_start,
    input  logic               i_byte_tx_done,
    input  logic [NB_BYTE-1:0] i_byte_rx_data,
    input  logic               i_byte_rx_done,
    output logic [NB_DATA-1:0] o_rx_word,
    output logic               o_rx_word_valid,
    output logic               o_rx_timeout_pulse
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int NB_IDLE =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [NB_IDLE:0] TO_VAL = (NB_IDLE + 1)'(TIMEOUT_CYCLES);

    localparam logic [NB_CNT-1:0] CNT_FULL = NB_CNT'(N_BYTES);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_BYTES - 1);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    // Byte that goes out next from a TX shift register.
    function automatic logic [NB_BYTE-1:0] head_byte(
        input logic [NB_DATA-1:0] w
    );
        if (LSB_FIRST) begin
            return w[NB_BYTE-1:0];
        end else begin
            return w[NB_DATA-1 -: NB_BYTE];
        end
    endfunction

    // Shift register contents after the head byte has been sent.
    function automatic logic [NB_DATA-1:0] drop_head(
        input logic [NB_DATA-1:0] w
    );
        if (LSB_FIRST) begin
            return w >> NB_BYTE;
        end else begin
            return w << NB_BYTE;
        end
    endfunction

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [NB_DATA-1:0] tx_sh_q, tx_sh_d;
    logic [NB_CNT-1:0]  rem_q,   rem_d;
    logic [NB_BYTE-1:0] byte_q,  byte_d;
    logic [NB_CNT-1:0]  n_eff;
    logic [NB_DATA-1:0] tx_sh_next;

    always_comb begin
        if (i_tx_n_bytes == '0 || i_tx_n_bytes > CNT_FULL) begin
            n_eff = CNT_FULL;
        end else begin
            n_eff = i_tx_n_bytes;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_sh_d    = tx_sh_q;
        rem_d      = rem_q;
        byte_d     = byte_q;
        tx_sh_next = drop_head(tx_sh_q);
        case (state_q)
            ST_IDLE: begin
                if (i_tx_start) begin
                    tx_sh_d = i_tx_data;
                    rem_d   = n_eff;
                    byte_d  = head_byte(i_tx_data);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // byte_q only changes when the next SEND is entered, so the
                // byte core sees stable data for the whole wait.
                if (i_byte_tx_done) begin
                    tx_sh_d = tx_sh_next;
                    rem_d   = rem_q - CNT_ONE;
                    if (rem_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        byte_d  = head_byte(tx_sh_next);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            tx_sh_q <= '0;
            rem_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_sh_q <= tx_sh_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
        end
    end

    assign o_tx_busy       = (state_q != ST_IDLE);
    assign o_tx_done_pulse = (state_q == ST_DONE);
    assign o_byte_tx_start = (state_q == ST_SEND);
    assign o_byte_tx_data  = byte_q;

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic [NB_CNT-1:0]  rx_cnt_q, rx_cnt_d;
    logic [NB_DATA-1:0] rx_sh_q,  rx_sh_d;
    logic [NB_IDLE-1:0] idle_q,   idle_d;
    logic [NB_DATA-1:0] word_q,   word_d;
    logic               valid_q,  valid_d;
    logic               tout_q,   tout_d;
    logic [NB_DATA-1:0] rx_asm;
    logic [NB_IDLE:0]   idle_inc;

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        rx_sh_d  = rx_sh_q;
        idle_d   = idle_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        tout_d   = 1'b0;
        rx_asm   = rx_sh_q;
        idle_inc = {1'b0, idle_q} + (NB_IDLE + 1)'(1);

        // Slot for the incoming byte is its arrival index, counted from
        // the LSB end or the MSB end depending on the byte order.
        for (int i = 0; i < N_BYTES; i++) begin
            if (rx_cnt_q == NB_CNT'(i)) begin
                if (LSB_FIRST) begin
                    rx_asm[i*NB_BYTE +: NB_BYTE] = i_byte_rx_data;
                end else begin
                    rx_asm[(N_BYTES-1-i)*NB_BYTE +: NB_BYTE] = i_byte_rx_data;
                end
            end
        end

        if (i_byte_rx_done) begin
            // A byte arriving on the timeout cycle wins over the timeout.
            idle_d = '0;
            if (rx_cnt_q == CNT_LAST) begin
                word_d   = rx_asm;
                valid_d  = 1'b1;
                rx_cnt_d = '0;
                rx_sh_d  = '0;
            end else begin
                rx_sh_d  = rx_asm;
                rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
        end else if (TO_EN && rx_cnt_q != '0) begin
            if (idle_inc == TO_VAL) begin
                tout_d   = 1'b1;
                rx_cnt_d = '0;
                rx_sh_d  = '0;
                idle_d   = '0;
            end else begin
                idle_d = idle_inc[NB_IDLE-1:0];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= '0;
            idle_q   <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            rx_sh_q  <= rx_sh_d;
            idle_q   <= idle_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            tout_q   <= tout_d;
        end
    end

    assign o_rx_word          = word_q;
    assign o_rx_word_valid    = valid_q;
    assign o_rx_timeout_pulse = tout_q;

endmodule

// File: tb/tb_uart_word_framer.sv
// tb_uart_word_framer: randomized + directed bench for uart_word_framer.
//   Instance A: LSB first, 100-cycle RX timeout. Instance B: MSB first, no timeout.
`timescale 1ns/1ps
module tb_uart_word_framer;

    localparam int TMO_A = 100;
    localparam bit LSB0 [2] = '{1'b1, 1'b0};
    localparam int TMO [2]  = '{TMO_A, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] tx_data = '0;
    logic [2:0]  tx_n = '0;
    logic        tx_start = 1'b0;
    logic        byte_tx_done = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_done = 1'b0;

    logic [1:0]       busy, done, bstart, valid, tout;
    logic [1:0][7:0]  bdata;
    logic [1:0][31:0] word;

    uart_word_framer #(
        .NB_DATA(32), .NB_BYTE(8), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(TMO_A)
    ) dut_a (
        .i_clock(clk), .i_reset(rst),
        .i_tx_data(tx_data), .i_tx_n_bytes(tx_n), .i_tx_start(tx_start),
        .o_tx_busy(busy[0]), .o_tx_done_pulse(done[0]),
        .o_byte_tx_data(bdata[0]), .o_byte_tx_start(bstart[0]),
        .i_byte_tx_done(byte_tx_done),
        .i_byte_rx_data(rx_data), .i_byte_rx_done(rx_done),
        .o_rx_word(word[0]), .o_rx_word_valid(valid[0]),
        .o_rx_timeout_pulse(tout[0])
    );

    uart_word_framer #(
        .NB_DATA(32), .NB_BYTE(8), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(0)
    ) dut_b (
        .i_clock(clk), .i_reset(rst),
        .i_tx_data(tx_data), .i_tx_n_bytes(tx_n), .i_tx_start(tx_start),
        .o_tx_busy(busy[1]), .o_tx_done_pulse(done[1]),
        .o_byte_tx_data(bdata[1]), .o_byte_tx_start(bstart[1]),
        .i_byte_tx_done(byte_tx_done),
        .i_byte_rx_data(rx_data), .i_byte_rx_done(rx_done),
        .o_rx_word(word[1]), .o_rx_word_valid(valid[1]),
        .o_rx_timeout_pulse(tout[1])
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    bit         e_busy, e_start, e_done, waiting;
    logic [7:0] eq0[$];
    logic [7:0] eq1[$];
    logic [7:0] e_cur [2];
    logic [7:0] part [2][4];
    int         pk [2];
    int         idle [2];
    logic [31:0] e_word [2];
    bit         e_valid [2];
    bit         e_tout [2];

    int         n_starts, n_dones;
    int         n_valid [2];
    int         n_tout [2];
    logic [7:0] log0[$];
    logic [7:0] log1[$];

    function automatic void model_reset();
        e_busy = 0; e_start = 0; e_done = 0; waiting = 0;
        eq0.delete(); eq1.delete();
        for (int i = 0; i < 2; i++) begin
            e_cur[i] = '0; pk[i] = 0; idle[i] = 0;
            e_word[i] = '0; e_valid[i] = 0; e_tout[i] = 0;
        end
    endfunction

    function automatic logic [31:0] assemble(int i);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            if (LSB0[i]) w = w | (32'(part[i][k]) << (8 * k));
            else         w = w | (32'(part[i][k]) << (8 * (3 - k)));
        end
        return w;
    endfunction

    function automatic void model_step();
        bit n_start, n_done, n_busy;
        int n;
        n_start = 0; n_done = 0; n_busy = e_busy;
        if (e_done) n_busy = 0;
        if (waiting && byte_tx_done) begin
            waiting = 0;
            if (eq0.size() == 0) n_done = 1;
            else n_start = 1;
        end
        if (e_start) waiting = 1;
        if (!e_busy && tx_start) begin
            n = (tx_n == 0 || tx_n > 4) ? 4 : int'(tx_n);
            for (int k = 0; k < n; k++) begin
                eq0.push_back(8'(tx_data >> (8 * k)));
                eq1.push_back(8'(tx_data >> (8 * (3 - k))));
            end
            n_start = 1; n_busy = 1;
        end
        e_start = n_start; e_done = n_done; e_busy = n_busy;
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 0; e_tout[i] = 0;
            if (rx_done) begin
                part[i][pk[i]] = rx_data;
                pk[i]++;
                idle[i] = 0;
                if (pk[i] == 4) begin
                    e_word[i] = assemble(i);
                    e_valid[i] = 1;
                    pk[i] = 0;
                end
            end else if (pk[i] > 0) begin
                idle[i]++;
                if (TMO[i] != 0 && idle[i] == TMO[i]) begin
                    e_tout[i] = 1; pk[i] = 0; idle[i] = 0;
                end
            end
        end
    endfunction

    // ---------------- compare process ----------------
    logic [7:0] ex;
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                check("rst_ctrl", 32'({busy[i], done[i], bstart[i],
                                       valid[i], tout[i], bdata[i]}), 32'h0);
                check("rst_word", word[i], 32'h0);
            end
            model_reset();
        end else begin
            for (int i = 0; i < 2; i++) begin
                check("tx_busy", 32'(busy[i]), 32'(e_busy));
                check("tx_start", 32'(bstart[i]), 32'(e_start));
                check("tx_done", 32'(done[i]), 32'(e_done));
            end
            if (e_start) begin
                ex = (eq0.size() > 0) ? eq0.pop_front() : 8'h00;
                e_cur[0] = ex;
                ex = (eq1.size() > 0) ? eq1.pop_front() : 8'h00;
                e_cur[1] = ex;
                check("tx_byte_a", 32'(bdata[0]), 32'(e_cur[0]));
                check("tx_byte_b", 32'(bdata[1]), 32'(e_cur[1]));
            end else if (waiting) begin
                check("tx_hold_a", 32'(bdata[0]), 32'(e_cur[0]));
                check("tx_hold_b", 32'(bdata[1]), 32'(e_cur[1]));
            end
            for (int i = 0; i < 2; i++) begin
                check("rx_word", word[i], e_word[i]);
                check("rx_valid", 32'(valid[i]), 32'(e_valid[i]));
                check("rx_tout", 32'(tout[i]), 32'(e_tout[i]));
            end
            if (bstart[0]) begin
                n_starts++;
                log0.push_back(bdata[0]);
                log1.push_back(bdata[1]);
            end
            if (done[0]) n_dones++;
            for (int i = 0; i < 2; i++) begin
                if (valid[i]) n_valid[i]++;
                if (tout[i]) n_tout[i]++;
            end
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    int fixed_delay = 10;
    bit spur_en = 0;
    bit pend = 0;
    int cd = 0;

    // Advance one cycle, clear pulses and act as the byte TX core.
    task automatic step();
        @(posedge clk);
        #1;
        tx_start = 0; rx_done = 0; byte_tx_done = 0;
        if (rst) begin
            pend = 0;
        end else if (pend) begin
            if (cd <= 1) begin
                byte_tx_done = 1; pend = 0;
            end else begin
                cd--;
            end
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            byte_tx_done = 1;
        end
        if (bstart[0]) begin
            pend = 1;
            cd = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 6));
        end
    endtask

    task automatic clear_logs();
        log0.delete(); log1.delete();
        n_starts = 0; n_dones = 0;
        for (int i = 0; i < 2; i++) begin
            n_valid[i] = 0; n_tout[i] = 0;
        end
    endtask

    function automatic logic [31:0] pack_log(int which);
        logic [31:0] r;
        r = '0;
        if (which == 0) foreach (log0[k]) r = (r << 8) | 32'(log0[k]);
        else            foreach (log1[k]) r = (r << 8) | 32'(log1[k]);
        return r;
    endfunction

    task automatic send_rx(logic [7:0] b);
        rx_data = b; rx_done = 1;
        step();
    endtask

    task automatic run_t1(string tag);
        step();
        clear_logs();
        tx_data = 32'hA1B2C3D4; tx_n = 3'd0; tx_start = 1;
        repeat (70) step();
        check({tag, "_a_bytes"}, pack_log(0), 32'hD4C3B2A1);
        check({tag, "_b_bytes"}, pack_log(1), 32'hA1B2C3D4);
        check({tag, "_count"}, 32'(log0.size()), 32'd4);
        check({tag, "_starts"}, 32'(n_starts), 32'd4);
        check({tag, "_dones"}, 32'(n_dones), 32'd1);
        check({tag, "_idle"}, 32'(busy[0]), 32'd0);
    endtask

    int gap = 0;

    initial begin
        repeat (3) step();
        rst = 0;

        // T1: full word, fixed 10-cycle byte core
        run_t1("t1");

        // T2: two bytes
        step();
        clear_logs();
        tx_data = 32'h11223344; tx_n = 3'd2; tx_start = 1;
        repeat (40) step();
        check("t2_b_bytes", pack_log(1), 32'h00001122);
        check("t2_a_bytes", pack_log(0), 32'h00004433);
        check("t2_starts", 32'(n_starts), 32'd2);
        check("t2_dones", 32'(n_dones), 32'd1);

        // T3: starts while busy are dropped
        step();
        clear_logs();
        tx_data = 32'hCAFEF00D; tx_n = 3'd0; tx_start = 1;
        repeat (5) step();
        tx_data = 32'h12345678; tx_n = 3'd1; tx_start = 1;
        repeat (20) step();
        tx_start = 1;
        repeat (50) step();
        check("t3_a_bytes", pack_log(0), 32'h0DF0FECA);
        check("t3_starts", 32'(n_starts), 32'd4);
        check("t3_dones", 32'(n_dones), 32'd1);

        // T4: RX word assembly
        clear_logs();
        for (int b = 1; b <= 4; b++) send_rx(8'(b));
        step();
        check("t4_model", e_word[0], 32'h04030201);
        check("t4_word_a", word[0], 32'h04030201);
        check("t4_word_b", word[1], 32'h01020304);
        check("t4_valid", 32'(n_valid[0]), 32'd1);
        send_rx(8'h05);
        repeat (3) step();
        check("t4_hold", word[0], 32'h04030201);
        check("t4_valid2", 32'(n_valid[0]), 32'd1);
        repeat (110) step();
        check("t4_tout_a", 32'(n_tout[0]), 32'd1);
        check("t4_tout_b", 32'(n_tout[1]), 32'd0);

        // T5: timeout after exactly 100 idle cycles
        clear_logs();
        send_rx(8'h55);
        send_rx(8'h66);
        repeat (99) step();
        check("t5_early", 32'(n_tout[0]), 32'd0);
        repeat (3) step();
        check("t5_tout", 32'(n_tout[0]), 32'd1);
        check("t5_hold", word[0], 32'h04030201);
        send_rx(8'hAA);
        send_rx(8'hBB);
        send_rx(8'hCC);
        send_rx(8'hDD);
        step();
        check("t5_model", e_word[0], 32'hDDCCBBAA);
        check("t5_word_a", word[0], 32'hDDCCBBAA);
        check("t5_word_b", word[1], 32'h055566AA);

        // T6: reset mid-TX and mid-RX
        clear_logs();
        step();
        tx_data = 32'h01020304; tx_n = 3'd0; tx_start = 1;
        rx_data = 8'h77; rx_done = 1;
        step();
        rx_data = 8'h88; rx_done = 1;
        repeat (4) step();
        rst = 1;
        step();
        rst = 0;
        repeat (60) step();
        check("t6_no_done", 32'(n_dones), 32'd0);
        check("t6_no_valid", 32'(n_valid[0]), 32'd0);
        check("t6_no_tout", 32'(n_tout[0]), 32'd0);
        check("t6_word", word[0], 32'h0);
        run_t1("t6_t1");

        // Randomized traffic
        fixed_delay = 0;
        spur_en = 1;
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 5) == 0) begin
                tx_start = 1;
                tx_data = $urandom;
                tx_n = 3'($urandom_range(0, 7));
            end
            if (gap == 0) begin
                rx_done = 1;
                rx_data = 8'($urandom);
                gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(95, 105))
                                                  : int'($urandom_range(0, 3));
            end else begin
                gap--;
            end
            rst = ($urandom_range(0, 1499) == 0);
        end
        rst = 0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
